elevator_ctrl_n: RTL

- Parametrised elevator controller for N floors, the next generation of the fixed 3-bit-request elevator.
- Latches multiple floor requests into a pending register and serves them with SCAN scheduling: keep the current direction while requests remain ahead, then reverse.
- Owns the travel timer, the door timer and the floor position. Outputs the current floor in binary and one-hot for the display decoder.
- Runs on the single system clock. Time advances only on a one-cycle tick enable from the existing frequency divider.

---
 rtl/elevator_pkg.sv | 25 ++
 rtl/tick_timer.sv | 28 ++
 rtl/elevator_ctrl_n.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// Shared types and floor-mask helpers for the N-floor SCAN elevator controller.
package elevator_pkg;

  localparam int MAX_FLOORS = 16;

  typedef enum logic [1:0] {IDLE, MOVE, DOOR} state_t;
  typedef enum logic {UP, DOWN} dir_t;

  function automatic logic [MAX_FLOORS-1:0] floor_mask_above(input logic [3:0] idx, input int n);
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_FLOORS; i++)
      if (i > int'(idx) && i < n) m[i] = 1'b1;
    return m;
  endfunction

  function automatic logic [MAX_FLOORS-1:0] floor_mask_below(input logic [3:0] idx, input int n);
    logic [MAX_FLOORS-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_FLOORS; i++)
      if (i < int'(idx) && i < n) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Tick-driven up-counter; done pulses on the tick that completes LIMIT counts, then wraps to 0.
module tick_timer #(
  parameter int LIMIT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_tick,
  input  logic i_en,
  input  logic i_clr,
  output logic o_done
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] r_count;

  assign o_done = i_en && i_tick && (r_count == CW'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (reset)
      r_count <= '0;
    else if (i_clr || o_done)
      r_count <= '0;
    else if (i_en && i_tick)
      r_count <= r_count + CW'(1);
  end

endmodule

// File: rtl/elevator_ctrl_n.sv
// SCAN elevator controller: latches floor requests, owns travel/door timers and floor position.
// Optional emergency stop input enabled by defining ELEV_ESTOP_EN.
module elevator_ctrl_n
  import elevator_pkg::*;
#(
  parameter int N_FLOORS     = 8,
  parameter int DOOR_TICKS   = 4,
  parameter int TRAVEL_TICKS = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic [N_FLOORS-1:0]         req,
`ifdef ELEV_ESTOP_EN
  input  logic                        estop,
`endif
  output logic [$clog2(N_FLOORS)-1:0] floor_idx,
  output logic [N_FLOORS-1:0]         floor_onehot,
  output logic [N_FLOORS-1:0]         pending,
  output logic                        moving_up,
  output logic                        moving_down,
  output logic                        door_open
);

  localparam int FW = $clog2(N_FLOORS);

  state_t              r_state, w_next_state;
  dir_t                r_dir, w_next_dir;
  logic [FW-1:0]       r_floor, w_next_floor, w_step;
  logic [N_FLOORS-1:0] r_onehot, r_pending, w_next_onehot, w_clr;
  logic                r_moving_up, r_moving_down, r_door_open;
  logic [MAX_FLOORS-1:0] w_pend16;
  logic                w_run, w_hold;
  logic                w_cur_above, w_cur_below, w_new_above, w_new_below, w_new_here;
  logic                w_travel_en, w_travel_clr, w_travel_done;
  logic                w_door_en, w_door_clr, w_door_done;

`ifdef ELEV_ESTOP_EN
  assign w_run = ~estop;
`else
  assign w_run = 1'b1;
`endif

  assign w_pend16    = MAX_FLOORS'(r_pending);
  assign w_step      = (r_dir == UP) ? r_floor + FW'(1) : r_floor - FW'(1);
  assign w_cur_above = |(w_pend16 & floor_mask_above(4'(r_floor), N_FLOORS));
  assign w_cur_below = |(w_pend16 & floor_mask_below(4'(r_floor), N_FLOORS));
  assign w_new_above = |(w_pend16 & floor_mask_above(4'(w_step), N_FLOORS));
  assign w_new_below = |(w_pend16 & floor_mask_below(4'(w_step), N_FLOORS));
  assign w_new_here  = r_pending[w_step];
  // a fresh call for the open floor keeps the door open
  assign w_hold      = (r_state == DOOR) && req[r_floor];

  assign w_travel_en  = (r_state == MOVE) && w_run;
  assign w_travel_clr = (r_state != MOVE);
  assign w_door_en    = (r_state == DOOR) && w_run;
  assign w_door_clr   = (r_state != DOOR) || (w_hold && w_run);

  tick_timer #(.LIMIT(TRAVEL_TICKS)) u_travel_timer (
    .clk    (clk),
    .reset  (reset),
    .i_tick (tick),
    .i_en   (w_travel_en),
    .i_clr  (w_travel_clr),
    .o_done (w_travel_done)
  );

  tick_timer #(.LIMIT(DOOR_TICKS)) u_door_timer (
    .clk    (clk),
    .reset  (reset),
    .i_tick (tick),
    .i_en   (w_door_en),
    .i_clr  (w_door_clr),
    .o_done (w_door_done)
  );

  always_comb begin
    w_next_state = r_state;
    w_next_dir   = r_dir;
    w_next_floor = r_floor;
    case (r_state)
      IDLE: begin
        if (w_run) begin
          if (r_pending[r_floor]) begin
            w_next_state = DOOR;
          end else if ((r_dir == UP && w_cur_above) || (r_dir == DOWN && w_cur_below)) begin
            w_next_state = MOVE;
          end else if (w_cur_above) begin
            w_next_state = MOVE;
            w_next_dir   = UP;
          end else if (w_cur_below) begin
            w_next_state = MOVE;
            w_next_dir   = DOWN;
          end
        end
      end
      MOVE: begin
        if (w_travel_done) begin
          w_next_floor = w_step;
          if (w_new_here) begin
            w_next_state = DOOR;
          end else if ((r_dir == UP && w_new_above) || (r_dir == DOWN && w_new_below)) begin
            w_next_state = MOVE;
          end else if (r_dir == UP && w_new_below) begin
            w_next_dir = DOWN;
          end else if (r_dir == DOWN && w_new_above) begin
            w_next_dir = UP;
          end else begin
            w_next_state = IDLE;
          end
        end
      end
      DOOR: begin
        if (w_door_done && !w_hold)
          w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign w_next_onehot = {{(N_FLOORS-1){1'b0}}, 1'b1} << w_next_floor;
  assign w_clr = (r_state == DOOR || w_next_state == DOOR) ? w_next_onehot : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= IDLE;
      r_dir         <= UP;
      r_floor       <= '0;
      r_onehot      <= {{(N_FLOORS-1){1'b0}}, 1'b1};
      r_pending     <= '0;
      r_moving_up   <= 1'b0;
      r_moving_down <= 1'b0;
      r_door_open   <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_dir         <= w_next_dir;
      r_floor       <= w_next_floor;
      r_onehot      <= w_next_onehot;
      r_pending     <= (r_pending | req) & ~w_clr;
      r_moving_up   <= (w_next_state == MOVE) && (w_next_dir == UP) && w_run;
      r_moving_down <= (w_next_state == MOVE) && (w_next_dir == DOWN) && w_run;
      r_door_open   <= (w_next_state == DOOR);
    end
  end

  assign floor_idx    = r_floor;
  assign floor_onehot = r_onehot;
  assign pending      = r_pending;
  assign moving_up    = r_moving_up;
  assign moving_down  = r_moving_down;
  assign door_open    = r_door_open;

  // travelling never points past the end floor it is on
  a_dir_floor: assert property (@(posedge clk) disable iff (reset)
    (r_state == MOVE) |-> !((r_dir == UP && r_floor == FW'(N_FLOORS - 1)) ||
                            (r_dir == DOWN && r_floor == '0)));

endmodule
